municao_jogador: RTL and testbench
==================================

// Module: municao_jogador
// PURPOSE
//  Player-side projectile: the upward counterpart of the enemy shot block. On a player
//  fire-button press it spawns a shot at the player position and moves it up one line per
//  move tick. It tests each tick for a hit on the enemy box, counts hits and drives the
//  shot's VGA pixel colour. It sits beside the enemy shot block; its R/G/B are OR-merged
//  in the top-level video mux.
// PARAMETERS
//  MOVE_DELAY  200000    clk cycles per 1-line upward step
//  COOLDOWN    25000000  clk cycles after shot ends before a new shot is accepted
//  Y_MIN       3         shot despawns when its Y reaches <= Y_MIN
//  SHOT_W      2         shot width in pixels
//  SHOT_LEN    20        shot height in pixels
//  ENEMY_W     40        enemy hit-box width in pixels
//  ENEMY_H     30        enemy hit-box height in pixels
// PORTS
//  clk            in   1   system/pixel clock
//  reset          in   1   asynchronous, active-high
//  btn_fire       in   1   fire button, active-low, asynchronous to clk
//  posX_jogador   in   11  player X (shot spawn X)
//  posY_jogador   in   11  player Y (shot spawn Y)
//  posX_inimigo   in   11  enemy box left edge
//  posY_inimigo   in   11  enemy box top edge
//  h_counter      in   10  VGA horizontal counter
//  v_counter      in   10  VGA vertical counter
//  posX_Municao1  out  11  shot X; 0 when no shot
//  posY_Municao1  out  11  shot Y; 0 when no shot
//  shot_active    out  1   high while in FLYING
//  hit            out  1   1-cycle pulse on enemy hit
//  hits_count     out  8   saturating hit counter
//  R, G, B        out  8   shot pixel colour
// BEHAVIOUR
//  Reset:
//  - All outputs 0, state IDLE, all counters 0.
//  Button input:
//  - btn_fire passes through a 2-flop synchroniser.
//  - fire_evt = 1-cycle pulse on the synchronised falling edge.
//  FSM IDLE -> FLYING -> COOLDOWN -> IDLE:
//  - IDLE: on fire_evt, latch X=posX_jogador and Y=posY_jogador, clear the move counter,
//    go to FLYING. Shot outputs take the latched values on the next cycle.
//  - FLYING: the move counter counts 0..MOVE_DELAY-1 and wraps; tick = counter==MOVE_DELAY-1.
//  - On tick, priority order:
//    (a) Hit if X>=ex && X<ex+ENEMY_W && Y>=ey && Y<ey+ENEMY_H. Assert hit for one cycle,
//        increment hits_count (saturates at 255), go to COOLDOWN.
//    (b) Else if Y<=Y_MIN, go to COOLDOWN with no hit.
//    (c) Else Y <= Y-1.
//  - COOLDOWN: count COOLDOWN cycles, then go to IDLE.
//    posX/posY_Municao1=0 and shot_active=0 from the cycle COOLDOWN is entered.
//  - fire_evt in FLYING or COOLDOWN is discarded, not queued.
//  - The button held low gives exactly one shot; a release and new press are needed.
//  Arithmetic:
//  - All compares are unsigned at 12 bits. h/v counters are zero-extended.
//  - ex+ENEMY_W and ey+ENEMY_H are computed without 11-bit wrap. No subtraction in compares.
//  Pixel (registered, 1-cycle latency from h/v):
//  - v<=2 or h<=96 -> 0,0,0.
//  - Else if shot_active && h in [X,X+SHOT_W) && v in [Y,Y+SHOT_LEN) -> R=0,G=255,B=0.
//  - Else 0,0,0.
//  Reset mid-flight: immediate return to IDLE, outputs cleared, hits_count cleared.
// TESTING (bench params MOVE_DELAY=4, COOLDOWN=10, Y_MIN=3)
//  - Reset: assert reset mid-cycle -> all outputs 0 at once; release, btn_fire=1 ->
//    shot_active stays 0.
//  - Fire: player (100,400), btn_fire low 5 cycles -> shot_active=1, pos=(100,400), then
//    Y=399 after 4 cycles, 398 after 8; one shot only.
//  - Hit: enemy (90,395), shot spawned at (100,400) -> hit pulses once when Y=424? no:
//    use spawn (100,430); hit pulses on the tick where Y=424, hits_count=1, shot_active=0
//    for 10 cycles, then IDLE.
//  - Miss/top: spawn (500,6), enemy far away -> Y=5,4,3, then despawn on the next tick,
//    hit never asserted.
//  - Ignore: second press during FLYING and during COOLDOWN -> no new shot; press after
//    IDLE -> new shot.
//  - Pixel/saturation: shot (200,100), h=201 v=119 -> G=255 one cycle later; h=202 or
//    v=120 -> black; h=96 -> black. Force 256 hits -> hits_count stays 255.
```

Note: the Hit test line is wrong as written. Use spawn (100,430) with enemy at (90,395). The box covers Y 395..424, so the hit pulses on the tick where Y reaches 424.

Source files
------------

// File: rtl/municao_jogador.sv
// Player projectile: spawns on a fire-button press, climbs one line per move tick,
// scores hits against the enemy box and paints itself green on the VGA raster.
module municao_jogador #(
  parameter int MOVE_DELAY = 200000,
  parameter int COOLDOWN   = 25000000,
  parameter int Y_MIN      = 3,
  parameter int SHOT_W     = 2,
  parameter int SHOT_LEN   = 20,
  parameter int ENEMY_W    = 40,
  parameter int ENEMY_H    = 30
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_fire,
  input  logic [10:0] posX_jogador,
  input  logic [10:0] posY_jogador,
  input  logic [10:0] posX_inimigo,
  input  logic [10:0] posY_inimigo,
  input  logic [9:0]  h_counter,
  input  logic [9:0]  v_counter,
  output logic [10:0] posX_Municao1,
  output logic [10:0] posY_Municao1,
  output logic        shot_active,
  output logic        hit,
  output logic [7:0]  hits_count,
  output logic [7:0]  R,
  output logic [7:0]  G,
  output logic [7:0]  B,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_FLYING   = 2'd1,
    S_COOLDOWN = 2'd2
  } state_t;

  localparam int MW = (MOVE_DELAY > 1) ? $clog2(MOVE_DELAY) : 1;
  localparam int CW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;
  localparam logic [MW-1:0] MOVE_LAST = MW'(MOVE_DELAY - 1);
  localparam logic [CW-1:0] CD_LAST   = CW'(COOLDOWN - 1);

  state_t         state_q, state_d;
  logic [10:0]    shot_x_q, shot_x_d;
  logic [10:0]    shot_y_q, shot_y_d;
  logic [MW-1:0]  move_cnt_q, move_cnt_d;
  logic [CW-1:0]  cd_cnt_q, cd_cnt_d;
  logic           hit_q, hit_d;
  logic [7:0]     hits_q, hits_d;
  logic [7:0]     g_q;
  logic           btn_s1_q, btn_s2_q, btn_prev_q;
  logic           fire_evt, tick, in_box, at_top, pix_on;
  logic [11:0]    x12, y12, ex12, ey12, h12, v12;

  // Button idles high, so the synchroniser resets to 1 to avoid a phantom press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_s1_q   <= 1'b1;
      btn_s2_q   <= 1'b1;
      btn_prev_q <= 1'b1;
    end else begin
      btn_s1_q   <= btn_fire;
      btn_s2_q   <= btn_s1_q;
      btn_prev_q <= btn_s2_q;
    end
  end

  assign fire_evt = btn_prev_q & ~btn_s2_q;

  // All geometry is compared at 12 bits so box edges past 2047 do not wrap.
  assign x12    = {1'b0, shot_x_q};
  assign y12    = {1'b0, shot_y_q};
  assign ex12   = {1'b0, posX_inimigo};
  assign ey12   = {1'b0, posY_inimigo};
  assign h12    = {2'b00, h_counter};
  assign v12    = {2'b00, v_counter};
  assign tick   = (move_cnt_q == MOVE_LAST);
  assign in_box = (x12 >= ex12) && (x12 < ex12 + 12'(ENEMY_W)) &&
                  (y12 >= ey12) && (y12 < ey12 + 12'(ENEMY_H));
  assign at_top = (y12 <= 12'(Y_MIN));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      shot_x_q   <= '0;
      shot_y_q   <= '0;
      move_cnt_q <= '0;
      cd_cnt_q   <= '0;
      hit_q      <= 1'b0;
      hits_q     <= '0;
    end else begin
      state_q    <= state_d;
      shot_x_q   <= shot_x_d;
      shot_y_q   <= shot_y_d;
      move_cnt_q <= move_cnt_d;
      cd_cnt_q   <= cd_cnt_d;
      hit_q      <= hit_d;
      hits_q     <= hits_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:     if (fire_evt) state_d = S_FLYING;
      S_FLYING:   if (tick && (in_box || at_top)) state_d = S_COOLDOWN;
      S_COOLDOWN: if (cd_cnt_q == CD_LAST) state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  // Presses outside IDLE fall through untouched, so they are dropped rather than queued.
  always_comb begin
    shot_x_d   = shot_x_q;
    shot_y_d   = shot_y_q;
    move_cnt_d = move_cnt_q;
    cd_cnt_d   = '0;
    hit_d      = 1'b0;
    hits_d     = hits_q;
    case (state_q)
      S_IDLE: begin
        if (fire_evt) begin
          shot_x_d   = posX_jogador;
          shot_y_d   = posY_jogador;
          move_cnt_d = '0;
        end
      end
      S_FLYING: begin
        move_cnt_d = tick ? '0 : move_cnt_q + 1'b1;
        if (tick) begin
          if (in_box) begin
            hit_d = 1'b1;
            if (hits_q != 8'hFF) hits_d = hits_q + 8'd1;
          end else if (!at_top) begin
            shot_y_d = shot_y_q - 11'd1;
          end
        end
      end
      S_COOLDOWN: cd_cnt_d = (cd_cnt_q == CD_LAST) ? '0 : cd_cnt_q + 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    shot_active   = (state_q == S_FLYING);
    posX_Municao1 = shot_active ? shot_x_q : 11'd0;
    posY_Municao1 = shot_active ? shot_y_q : 11'd0;
    hit           = hit_q;
    hits_count    = hits_q;
    dbg_state_o   = state_q;
  end

  // Rows 0..2 and columns 0..96 are blanking and always stay black.
  assign pix_on = shot_active && (v12 > 12'd2) && (h12 > 12'd96) &&
                  (h12 >= x12) && (h12 < x12 + 12'(SHOT_W)) &&
                  (v12 >= y12) && (v12 < y12 + 12'(SHOT_LEN));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) g_q <= 8'h00;
    else       g_q <= pix_on ? 8'hFF : 8'h00;
  end

  assign R = 8'h00;
  assign G = g_q;
  assign B = 8'h00;

endmodule

// File: tb/tb_municao_jogador.sv
// Bench for municao_jogador: directed scenarios plus randomized traffic, all checked
// cycle by cycle against a behavioural model of the projectile.
module tb_municao_jogador;

  localparam int MD = 4;
  localparam int CD = 10;
  localparam int YM = 3;

  logic        clk, reset, btn_fire;
  logic [10:0] posX_jogador, posY_jogador, posX_inimigo, posY_inimigo;
  logic [9:0]  h_counter, v_counter;
  logic [10:0] posX_Municao1, posY_Municao1;
  logic        shot_active, hit;
  logic [7:0]  hits_count, R, G, B;
  logic [1:0]  dbg_state;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 0;
  logic [7:0] exp_q[$];

  municao_jogador #(
    .MOVE_DELAY(MD), .COOLDOWN(CD), .Y_MIN(YM),
    .SHOT_W(2), .SHOT_LEN(20), .ENEMY_W(40), .ENEMY_H(30)
  ) dut (
    .clk(clk), .reset(reset), .btn_fire(btn_fire),
    .posX_jogador(posX_jogador), .posY_jogador(posY_jogador),
    .posX_inimigo(posX_inimigo), .posY_inimigo(posY_inimigo),
    .h_counter(h_counter), .v_counter(v_counter),
    .posX_Municao1(posX_Municao1), .posY_Municao1(posY_Municao1),
    .shot_active(shot_active), .hit(hit), .hits_count(hits_count),
    .R(R), .G(G), .B(B), .dbg_state_o(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // A shot is a point that rises one line every MD cycles of flight; after it
  // ends, CD cycles must pass before a press is honoured again.
  int m_active, m_cool, m_x, m_y, m_age, m_hit, m_hits, m_g;
  bit h_s1, h_s2, h_prev, m_fire;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_active = 0; m_cool = 0; m_x = 0; m_y = 0; m_age = 0;
      m_hit = 0; m_hits = 0; m_g = 0;
      h_s1 = 1; h_s2 = 1; h_prev = 1;
      exp_q.delete();
    end else begin
      m_fire = h_prev && !h_s2;
      m_g = (m_active != 0 && int'(v_counter) > 2 && int'(h_counter) > 96 &&
             int'(h_counter) >= m_x && int'(h_counter) < m_x + 2 &&
             int'(v_counter) >= m_y && int'(v_counter) < m_y + 20) ? 255 : 0;
      m_hit = 0;
      if (m_active != 0) begin
        m_age++;
        if (m_age % MD == 0) begin
          if (m_x >= int'(posX_inimigo) && m_x < int'(posX_inimigo) + 40 &&
              m_y >= int'(posY_inimigo) && m_y < int'(posY_inimigo) + 30) begin
            m_hit = 1;
            if (m_hits < 255) m_hits++;
            exp_q.push_back(8'(m_hits));
            m_active = 0; m_cool = CD;
          end else if (m_y <= YM) begin
            m_active = 0; m_cool = CD;
          end else begin
            m_y--;
          end
        end
      end else if (m_cool > 0) begin
        m_cool--;
      end else if (m_fire) begin
        m_active = 1; m_x = int'(posX_jogador); m_y = int'(posY_jogador); m_age = 0;
      end
      h_prev = h_s2; h_s2 = h_s1; h_s1 = btn_fire;
    end
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (chk_en && !reset) begin
      chk("posX", posX_Municao1, (m_active != 0) ? m_x : 0);
      chk("posY", posY_Municao1, (m_active != 0) ? m_y : 0);
      chk("active", shot_active, m_active);
      chk("hit", hit, m_hit);
      chk("hits_count", hits_count, m_hits);
      chk("R", R, 0);
      chk("G", G, m_g);
      chk("B", B, 0);
      if (hit) begin
        if (exp_q.size() == 0) chk("hit_unexpected", 1, 0);
        else chk("hit_sb", hits_count, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_pos(input int px, input int py, input int ex, input int ey);
    posX_jogador = 11'(px); posY_jogador = 11'(py);
    posX_inimigo = 11'(ex); posY_inimigo = 11'(ey);
  endtask

  task automatic press(input int n);
    @(negedge clk) btn_fire = 1'b0;
    repeat (n) @(negedge clk);
    btn_fire = 1'b1;
  endtask

  task automatic sync_reset();
    @(negedge clk) reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // which: 0 = shot_active, 1 = hit. Expired budget counts as a failed comparison.
  task automatic wait_sig(input int which, input bit val, input int budget, input string tag);
    bit found = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (((which == 0) ? shot_active : hit) == val) begin
        found = 1;
        break;
      end
    end
    chk(tag, found, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int last_y, n_hit, min_y;
    reset = 1'b1; btn_fire = 1'b1;
    h_counter = '0; v_counter = '0;
    set_pos(100, 400, 1000, 1000);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    chk_en = 1;

    // Idle with button released: no shot appears.
    repeat (10) @(negedge clk);
    chk("idle_active", shot_active, 0);

    // Fire and climb.
    press(5);
    wait_sig(0, 1'b1, 10, "fire_wait");
    chk("spawn_x", posX_Municao1, 100);
    chk("spawn_y", posY_Municao1, 400);
    repeat (4) @(negedge clk);
    chk("y_step1", posY_Municao1, 399);
    repeat (4) @(negedge clk);
    chk("y_step2", posY_Municao1, 398);

    // Presses while flying and while cooling down are dropped.
    set_pos(300, 300, 1000, 1000);
    press(3);
    repeat (10) @(negedge clk);
    chk("fly_ignore_x", posX_Municao1, 100);
    wait_sig(0, 1'b0, 2000, "fly_end");
    press(2);
    repeat (15) @(negedge clk);
    chk("cool_ignore", shot_active, 0);
    press(2);
    wait_sig(0, 1'b1, 10, "refire");
    chk("refire_x", posX_Municao1, 300);

    // Asynchronous reset in mid-flight clears everything immediately.
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rst_posX", posX_Municao1, 0);
    chk("rst_posY", posY_Municao1, 0);
    chk("rst_active", shot_active, 0);
    chk("rst_hits", hits_count, 0);
    chk("rst_G", G, 0);
    chk("rst_state", dbg_state, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // Hit: box spans Y 395..424, so the hit lands on the tick at Y=424.
    set_pos(100, 430, 90, 395);
    press(2);
    wait_sig(0, 1'b1, 10, "hit_spawn");
    last_y = 0; n_hit = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (hit) begin n_hit = 1; break; end
      last_y = int'(posY_Municao1);
    end
    chk("hit_seen", n_hit, 1);
    chk("hit_y", last_y, 424);
    chk("hit_count1", hits_count, 1);
    n_hit = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (hit) n_hit++;
    end
    chk("hit_once", n_hit, 0);

    // Top of screen: climbs to Y_MIN then despawns without a hit.
    sync_reset();
    set_pos(500, 6, 1000, 1000);
    press(2);
    wait_sig(0, 1'b1, 10, "top_spawn");
    min_y = 2047; n_hit = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (hit) n_hit++;
      if (shot_active && int'(posY_Municao1) < min_y) min_y = int'(posY_Municao1);
    end
    chk("top_min_y", min_y, 3);
    chk("top_no_hit", n_hit, 0);
    chk("top_ended", shot_active, 0);

    // Pixel window, checked within the first move period at Y=100.
    sync_reset();
    set_pos(200, 100, 1000, 1000);
    press(2);
    wait_sig(0, 1'b1, 10, "pix_spawn");
    h_counter = 10'd201; v_counter = 10'd119;
    @(negedge clk); chk("pix_on_G", G, 255); chk("pix_on_R", R, 0);
    h_counter = 10'd202;
    @(negedge clk); chk("pix_h_edge", G, 0);
    h_counter = 10'd201; v_counter = 10'd120;
    @(negedge clk); chk("pix_v_edge", G, 0);
    h_counter = 10'd96; v_counter = 10'd119;
    @(negedge clk); chk("pix_h_blank", G, 0);
    h_counter = '0; v_counter = '0;

    // Saturation: every shot spawns inside the enemy box.
    sync_reset();
    set_pos(10, 10, 0, 0);
    for (int k = 0; k < 260; k++) begin
      press(2);
      wait_sig(1, 1'b1, 20, "sat_hit");
      repeat (12) @(negedge clk);
    end
    chk("sat_count", hits_count, 255);

    // Randomized traffic near the enemy box, including the 11-bit top end.
    sync_reset();
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 7) == 0) btn_fire = ~btn_fire;
      if ($urandom_range(0, 63) == 0) begin
        if ($urandom_range(0, 3) == 0)
          set_pos($urandom_range(2000, 2047), $urandom_range(20, 60),
                  $urandom_range(1990, 2047), $urandom_range(0, 40));
        else
          set_pos($urandom_range(50, 150), $urandom_range(4, 80),
                  $urandom_range(40, 160), $urandom_range(0, 60));
      end
      h_counter = 10'($urandom_range(90, 170));
      v_counter = 10'($urandom_range(0, 110));
    end
    btn_fire = 1'b1;
    repeat (5) @(negedge clk);
    chk("exp_q_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
